// File: rtl/slime_contact_detect.sv
// rtl/slime_contact_detect.sv - per-frame player/slime box overlap scan producing damage and stomp results
module slime_contact_detect #(
   parameter int N_SLIME      = 4,
   parameter int COORD_W      = 10,
   parameter int HIT_W        = 16,
   parameter int HIT_H        = 16,
   parameter int STOMP_MARGIN = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic [COORD_W-1:0]         player_x,
   input  logic [COORD_W-1:0]         player_y,
   input  logic                       player_falling,
   input  logic [N_SLIME*COORD_W-1:0] slime_x,
   input  logic [N_SLIME*COORD_W-1:0] slime_y,
   input  logic [N_SLIME-1:0]         slime_alive,
   output logic [1:0]                 slim_damage,
   output logic [N_SLIME-1:0]         slime_stomp,
   output logic                       result_valid,
   output logic                       busy
);

   localparam int IDX_W = (N_SLIME > 1) ? $clog2(N_SLIME) : 1;
   localparam logic [IDX_W-1:0]   LP_LAST   = IDX_W'(N_SLIME - 1);
   localparam logic [COORD_W:0]   LP_HIT_W  = (COORD_W+1)'(HIT_W);
   localparam logic [COORD_W:0]   LP_HIT_H  = (COORD_W+1)'(HIT_H);
   localparam logic [COORD_W:0]   LP_MARGIN = (COORD_W+1)'(STOMP_MARGIN);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_SCAN,
      ST_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [COORD_W-1:0]         r_px;
   logic [COORD_W-1:0]         r_py;
   logic                       r_falling;
   logic [N_SLIME*COORD_W-1:0] r_sx_all;
   logic [N_SLIME*COORD_W-1:0] r_sy_all;
   logic [N_SLIME-1:0]         r_alive;
   logic [IDX_W-1:0]           r_idx;
   logic [1:0]                 r_hits;
   logic [N_SLIME-1:0]         r_mask;
   logic [1:0]                 r_damage;
   logic [N_SLIME-1:0]         r_stomp_out;
   logic                       r_valid;

   int                 w_base;
   logic [COORD_W-1:0] w_sx;
   logic [COORD_W-1:0] w_sy;
   logic [COORD_W-1:0] w_dx;
   logic [COORD_W-1:0] w_dy;
   logic               w_overlap;
   logic               w_stomp;

   // Geometry for the slime currently addressed by the scan index, from the snapshot only.
   assign w_base    = int'(r_idx) * COORD_W;
   assign w_sx      = r_sx_all[w_base +: COORD_W];
   assign w_sy      = r_sy_all[w_base +: COORD_W];
   assign w_dx      = (r_px >= w_sx) ? (r_px - w_sx) : (w_sx - r_px);
   assign w_dy      = (r_py >= w_sy) ? (r_py - w_sy) : (w_sy - r_py);
   assign w_overlap = r_alive[r_idx] && ({1'b0, w_dx} < LP_HIT_W) && ({1'b0, w_dy} < LP_HIT_H);
   // Player must be at least the margin above the slime; y grows downward.
   assign w_stomp   = w_overlap && r_falling && (({1'b0, r_py} + LP_MARGIN) <= {1'b0, w_sy});

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (frame_tick) w_next = ST_SNAP;
         ST_SNAP: w_next = ST_SCAN;
         ST_SCAN: if (r_idx == LP_LAST) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_px        <= '0;
         r_py        <= '0;
         r_falling   <= 1'b0;
         r_sx_all    <= '0;
         r_sy_all    <= '0;
         r_alive     <= '0;
         r_idx       <= '0;
         r_hits      <= '0;
         r_mask      <= '0;
         r_damage    <= '0;
         r_stomp_out <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_stomp_out <= '0;
         case (r_state)
            ST_SNAP: begin
               r_px      <= player_x;
               r_py      <= player_y;
               r_falling <= player_falling;
               r_sx_all  <= slime_x;
               r_sy_all  <= slime_y;
               r_alive   <= slime_alive;
               r_idx     <= '0;
               r_hits    <= '0;
               r_mask    <= '0;
            end
            ST_SCAN: begin
               // A stomp takes precedence: a stomped slime never also counts as damage.
               if (w_stomp) begin
                  r_mask[r_idx] <= 1'b1;
               end else if (w_overlap && (r_hits != 2'd2)) begin
                  r_hits <= r_hits + 2'd1;
               end
               r_idx <= r_idx + 1'b1;
            end
            ST_DONE: begin
               r_damage    <= r_hits;
               r_stomp_out <= r_mask;
               r_valid     <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign slim_damage  = r_damage;
   assign slime_stomp  = r_stomp_out;
   assign result_valid = r_valid;
   assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/slime_contact_detect.md
Name: slime_contact_detect

Overview:
- Upstream stage of the health counter: decides once per game frame whether the player sprite overlaps any live slime.
- Produces the 2-bit slim_damage code that the health counter consumes.
- Also emits per-slime stomp pulses to the slime manager, for kills from above.
- Snapshots positions on a frame tick, then scans slimes one per clock with an axis-aligned box test.

Parameters:
- N_SLIME, 4, number of slimes scanned (1..8).
- COORD_W, 10, width of every x/y coordinate (unsigned, y grows downward).
- HIT_W, 16, horizontal overlap threshold in pixels.
- HIT_H, 16, vertical overlap threshold in pixels.
- STOMP_MARGIN, 8, minimum height of the player above the slime for a stomp.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse marking the start of a frame.
- player_x  input  COORD_W  player x position.
- player_y  input  COORD_W  player y position.
- player_falling  input  1  player vertical velocity is downward.
- slime_x  input  N_SLIME*COORD_W  packed slime x positions; slime i is at [i*COORD_W +: COORD_W].
- slime_y  input  N_SLIME*COORD_W  packed slime y positions, same packing.
- slime_alive  input  N_SLIME  per-slime live flag.
- slim_damage  output  2  0 none, 1 one damaging contact, 2 two or more damaging contacts, 3 never driven.
- slime_stomp  output  N_SLIME  one-cycle pulse per slime stomped this frame.
- result_valid  output  1  one-cycle pulse when slim_damage and slime_stomp update.
- busy  output  1  high while a scan is in progress (states SNAP..DONE).

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Snapshot registers, scan index and hit counter are cleared.
  - Reset mid-scan abandons the scan; the partial result is never published.
- States:
  - IDLE -> SNAP on frame_tick.
  - SNAP -> SCAN.
  - SCAN stays for N_SLIME cycles (index 0..N_SLIME-1).
  - DONE -> IDLE.
- SNAP:
  - Registers player_x, player_y, player_falling, slime_x, slime_y and slime_alive.
  - Clears the hit counter and the stomp mask.
  - All later tests use only the snapshot; input changes during a scan have no effect.
- SCAN, slime i, each cycle:
  - Compute dx = |px - sx| and dy = |py - sy| as unsigned differences, larger minus smaller, no wrap.
  - overlap = alive[i] && dx < HIT_W && dy < HIT_H.
  - stomp = overlap && falling && (py + STOMP_MARGIN <= sy).
  - Compute py + STOMP_MARGIN in COORD_W+1 bits so it cannot overflow.
  - If stomp: set stomp mask bit i.
  - Else if overlap: increment the hit counter, saturating at 2.
  - Exactly at dx == HIT_W (or dy == HIT_H) there is no overlap.
- DONE (one cycle):
  - slim_damage <= hit counter.
  - slime_stomp <= stomp mask.
  - result_valid <= 1.
- Next cycle:
  - slime_stomp and result_valid return to 0.
  - slim_damage holds until the next DONE or reset.
- Latency: frame_tick sampled at edge T gives SNAP at T+1, SCAN at T+2..T+N_SLIME+1, and outputs at T+N_SLIME+2.
- frame_tick is accepted only in IDLE; ticks during SNAP, SCAN or DONE are dropped, with no queuing.
- busy = (state != IDLE).
- A slime both stomped and touching is counted only as a stomp, never as damage.
- With all slime_alive bits 0, a scan still runs and publishes slim_damage=0.

Test Plan:
1. Reset, then hold reset high with no tick for 20 cycles -> slim_damage=0, slime_stomp=0, busy=0, result_valid never pulses.
2. Player (100,100), slime0 (110,105) alive, others dead; pulse tick at edge T -> result_valid at T+6 (N_SLIME=4), slim_damage=1, slime_stomp=0.
3. Player (100,100), slime0 (110,105) and slime2 (95,90) alive, slime3 (100,100) alive -> slim_damage=2 (saturated), slime_stomp=0.
4. Player (200,80) falling, slime1 (205,90) alive -> slime_stomp=4'b0010 for exactly one cycle, slim_damage=0. Repeat with player_falling=0 -> slim_damage=1, slime_stomp=0.
5. Boundary: player (100,100), slime0 at (116,100) gives slim_damage=0; slime0 at (115,100) gives slim_damage=1.
6. Second tick 2 cycles after the first -> ignored, one result_valid only. Next, move slime0 to (300,300) after SNAP -> result still reflects the snapshot. Finally, assert reset during SCAN -> no result_valid, slim_damage=0, state IDLE.
